pipe_multdiv: RTL and testbench
===============================

Name: pipe_multdiv

Overview:
Multi-cycle signed multiply/divide unit consumed by the execute (X) stage of the 5-stage pipeline. It handles mul/div ALU ops. X launches an op with a one-cycle start pulse, holds the instruction in DX while busy, and captures the result into XM on data_resultRDY. It is a neighbour of the ALU in X, fed by DX operands (post-bypass) and feeding XM.O and the rstatus exception path.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported, the parameter exists for constants only.
MUL_LAT, 17, edges from start-sampling edge to data_resultRDY rise for multiply.
DIV_LAT, 33, edges from start-sampling edge to data_resultRDY rise for divide.

Ports:
clock  input  1  master clock, rising edge.
reset  input  1  asynchronous, active-high reset.
data_operandA  input  32  signed multiplicand / dividend; sampled only on the start edge.
data_operandB  input  32  signed multiplier / divisor; sampled only on the start edge.
ctrl_MULT  input  1  one-cycle start pulse, multiply.
ctrl_DIV  input  1  one-cycle start pulse, divide.
data_result  output  32  signed result, low 32 bits.
data_exception  output  1  overflow or divide-by-zero flag; valid with data_resultRDY.
data_resultRDY  output  1  one-cycle pulse: result valid.
busy  output  1  op in flight; X stage stalls FD/DX while high.

Behaviour:
- Reset is asynchronous and active-high. State goes to IDLE, counter to 0, all outputs to 0. Reset mid-operation aborts the op; no RDY pulse is issued afterwards.
- States: IDLE, MUL_RUN, DIV_RUN, FIX.
- IDLE + ctrl_MULT -> MUL_RUN; IDLE + ctrl_DIV -> DIV_RUN; counter cleared.
- MUL_RUN: radix-4 modified Booth, one 2-bit recode step per cycle, 16 cycles, 66-bit product register (sign-extended multiplicand). Then -> FIX.
- DIV_RUN: non-restoring division on magnitudes, one quotient bit per cycle, 32 cycles. Then -> FIX.
- FIX (1 cycle): sign correction, exception evaluation, register data_result/data_exception, then -> IDLE. data_resultRDY is high in the cycle after FIX, exactly one cycle.
- Latency: if the start is sampled at edge 0, RDY rises after edge MUL_LAT (17) for multiply or DIV_LAT (33) for divide.
- busy is high from edge 1 until the edge that raises RDY. busy is low while RDY is high.
- data_result and data_exception hold their values until the next start is sampled, then go to 0.
- Multiply overflow: data_exception=1 when product bits [63:31] are not all equal. data_result is still the low 32 bits.
- Divide: the quotient truncates toward zero, with sign = signA ^ signB. The remainder is discarded.
- Divide by zero: result 0, exception 1, full DIV_LAT latency (no fast path).
- 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
- ctrl_MULT and ctrl_DIV asserted in the same cycle: MULT wins, DIV is ignored.
- A start while busy aborts the current op and restarts with the new operands and op; only the new op produces RDY.
- A start in the same cycle as RDY is legal and is accepted normally.
- Operand inputs are don't-care except on the start edge.

Decomposition:
- multdiv_pkg holds: state encoding (IDLE/MUL_RUN/DIV_RUN/FIX), MUL_STEPS=16, DIV_STEPS=32, MUL_LAT, DIV_LAT, and the 3-bit Booth recode constants (0, ±M, ±2M).
- Sub-module booth_r4_step: combinational recode of 3 product bits to an addend (0/±M/±2M), shared add, arithmetic shift right by 2.
- The divide step stays inline in pipe_multdiv.

Test Plan:
- MULT 7 x -3 (0x00000007, 0xFFFFFFFD) -> RDY after edge 17, result 0xFFFFFFEB, exc 0, busy low at RDY.
- MULT 0x00010000 x 0x00010000 -> result 0x00000000, exc 1. Also 0x80000000 x 0xFFFFFFFF -> 0x80000000, exc 1.
- DIV -100 / 7 (0xFFFFFF9C, 0x00000007) -> RDY after edge 33, result 0xFFFFFFF2 (-14), exc 0. Also 100 / -7 -> 0xFFFFFFF2.
- DIV 5 / 0 -> RDY after edge 33, result 0, exc 1. Also 0x80000000 / 0xFFFFFFFF -> 0x80000000, exc 1.
- Restart: MULT 3x4 at edge 0, DIV 20/3 at edge 5 -> exactly one RDY, after edge 38, result 6. Simultaneous ctrl_MULT+ctrl_DIV with 6,2 -> RDY at 17, result 12.
- Reset asserted mid-DIV (edge 10, async between edges) -> outputs 0 immediately, no RDY through edge 40. A following MULT 2x2 -> result 4 at the normal latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared state encoding, step counts and Booth recode constants for the
// multi-cycle multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH     = 32;
  localparam int MUL_STEPS = 16;
  localparam int DIV_STEPS = 32;
  localparam int MUL_LAT   = 17;
  localparam int DIV_LAT   = 33;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    FIX     = 2'd3
  } md_state_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO   = 3'd0,
    BOOTH_POS_M  = 3'd1,
    BOOTH_POS_2M = 3'd2,
    BOOTH_NEG_M  = 3'd5,
    BOOTH_NEG_2M = 3'd6
  } booth_op_e;

  // Bits are {q[i+1], q[i], q[i-1]} of the multiplier.
  function automatic booth_op_e booth_recode(input logic [2:0] bits);
    booth_op_e op;
    case (bits)
      3'b001, 3'b010: op = BOOTH_POS_M;
      3'b011:         op = BOOTH_POS_2M;
      3'b100:         op = BOOTH_NEG_2M;
      3'b101, 3'b110: op = BOOTH_NEG_M;
      default:        op = BOOTH_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipe_multdiv_booth_r4_step.sv
// One radix-4 Booth iteration on the 66-bit product register
// {high[32:0], multiplier[31:0], q_minus1}.
module booth_r4_step (
  input  logic [65:0] prod_in,
  input  logic [31:0] mcand,
  output logic [65:0] prod_out
);
  import multdiv_pkg::*;

  logic [33:0] m_ext;
  logic [33:0] addend;
  logic [33:0] sum;

  // The add is done one bit wider than the stored high part because
  // high + 2M can exceed 33 bits before the shift brings it back in range.
  always_comb begin
    m_ext  = {{2{mcand[31]}}, mcand};
    addend = '0;
    case (booth_recode(prod_in[2:0]))
      BOOTH_POS_M:  addend = m_ext;
      BOOTH_POS_2M: addend = {m_ext[32:0], 1'b0};
      BOOTH_NEG_M:  addend = -m_ext;
      BOOTH_NEG_2M: addend = -{m_ext[32:0], 1'b0};
      default:      addend = '0;
    endcase
    sum      = {prod_in[65], prod_in[65:33]} + addend;
    prod_out = {sum[33], sum[33:2], sum[1:0], prod_in[32:2]};
  end

endmodule

// File: rtl/pipe_multdiv.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit
// for the execute stage; one start pulse in, one result-ready pulse out.
module pipe_multdiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 17,
  parameter int DIV_LAT = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  import multdiv_pkg::*;

  md_state_e   state_q, state_d;
  logic [5:0]  count_q;
  logic        is_mul_q;
  logic [65:0] prod_q, prod_next;
  logic [31:0] mcand_q;
  logic [33:0] rem_q, rem_next, rem_shift;
  logic [31:0] quo_q, quo_next, dvs_q;
  logic        neg_q, dvz_q, ovf_q;
  logic        start;
  logic        last_step;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] fix_result;
  logic        fix_exc;

  booth_r4_step u_booth (
    .prod_in  (prod_q),
    .mcand    (mcand_q),
    .prod_out (prod_next)
  );

  always_comb begin
    start     = ctrl_MULT | ctrl_DIV;
    last_step = (state_q == MUL_RUN && count_q == 6'(MUL_LAT - 2)) ||
                (state_q == DIV_RUN && count_q == 6'(DIV_LAT - 2));
    state_d   = state_q;
    case (state_q)
      MUL_RUN, DIV_RUN: if (last_step) state_d = FIX;
      FIX:              state_d = IDLE;
      default:          state_d = state_q;
    endcase
    // A new start always wins, including a restart of an op in flight.
    if (start) state_d = ctrl_MULT ? MUL_RUN : DIV_RUN;
    busy = (state_q == FIX) ||
           ((state_q == MUL_RUN || state_q == DIV_RUN) && count_q != 6'd0);
  end

  always_comb begin
    rem_shift = {rem_q[32:0], quo_q[31]};
    rem_next  = rem_q[33] ? rem_shift + {2'b00, dvs_q}
                          : rem_shift - {2'b00, dvs_q};
    quo_next  = {quo_q[30:0], ~rem_next[33]};
  end

  // Sign fix-up and exception evaluation, registered in the FIX cycle.
  always_comb begin
    product    = prod_q[64:1];
    quotient   = neg_q ? -quo_q : quo_q;
    fix_result = '0;
    fix_exc    = 1'b0;
    if (is_mul_q) begin
      fix_result = product[31:0];
      fix_exc    = product[63:31] != {33{product[63]}};
    end else begin
      fix_result = dvz_q ? 32'd0 : quotient;
      fix_exc    = dvz_q | ovf_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      is_mul_q       <= 1'b0;
      prod_q         <= '0;
      mcand_q        <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      neg_q          <= 1'b0;
      dvz_q          <= 1'b0;
      ovf_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_resultRDY <= (state_q == FIX) && !start;
      if (start) begin
        count_q        <= '0;
        is_mul_q       <= ctrl_MULT;
        mcand_q        <= data_operandA;
        prod_q         <= {33'd0, data_operandB, 1'b0};
        rem_q          <= '0;
        quo_q          <= data_operandA[31] ? -data_operandA : data_operandA;
        dvs_q          <= data_operandB[31] ? -data_operandB : data_operandB;
        neg_q          <= data_operandA[31] ^ data_operandB[31];
        dvz_q          <= data_operandB == 32'd0;
        ovf_q          <= data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
        data_result    <= '0;
        data_exception <= 1'b0;
      end else begin
        case (state_q)
          MUL_RUN: begin
            prod_q  <= prod_next;
            count_q <= count_q + 6'd1;
          end
          DIV_RUN: begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + 6'd1;
          end
          FIX: begin
            data_result    <= fix_result;
            data_exception <= fix_exc;
          end
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_multdiv.sv
// Self-checking bench for pipe_multdiv: directed vector table, corner-case
// sequences and randomized ops against an arithmetic reference model.
module tb_pipe_multdiv;

  localparam int MUL_LAT = 17;
  localparam int DIV_LAT = 33;
  localparam int TIMEOUT = 60;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pipe_multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Arithmetic reference: full 64-bit product, truncating signed quotient.
  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output bit exc);
    longint p;
    int     q;
    if (is_mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      q   = $signed(a) / $signed(b);
      res = q;
      exc = 1'b0;
    end
  endfunction

  // Drives a start pulse; returns #1 after the sampling edge (edge 0).
  task automatic apply_stimulus(input bit do_mul, input bit do_div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = do_mul;
    ctrl_DIV      = do_div;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check_output("start clears result", data_result, 32'd0);
  endtask

  task automatic wait_rdy(output int edges);
    edges = -1;
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) check_output("busy after edge 1", {31'd0, busy}, 32'd1);
      if (data_resultRDY) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic run_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit exp_exc, input string tag);
    int edges;
    apply_stimulus(is_mul, !is_mul, a, b);
    wait_rdy(edges);
    check_output({tag, " latency"}, edges, is_mul ? MUL_LAT : DIV_LAT);
    check_output({tag, " result"}, data_result, exp_res);
    check_output({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
    check_output({tag, " busy at rdy"}, {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    check_output({tag, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
    check_output({tag, " result held"}, data_result, exp_res);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 2000)) - 32'd1000;
      2: case ($urandom_range(0, 4))
           0: v = 32'd0;
           1: v = 32'd1;
           2: v = 32'hFFFF_FFFF;
           3: v = 32'h8000_0000;
           default: v = 32'h7FFF_FFFF;
         endcase
      default: v = 32'($urandom_range(0, 70000));
    endcase
    return v;
  endfunction

  initial begin
    int          edges, pulses, first_edge;
    logic [31:0] cap_res, exp_res;
    bit          cap_exc, exp_exc, is_mul;
    logic [31:0] a, b;

    vecs.push_back('{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul 7x-3"});
    vecs.push_back('{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul 2^16 sq"});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul min x -1"});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, "mul min x 1"});
    vecs.push_back('{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, "mul max sq"});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul -1x-1"});
    vecs.push_back('{1'b0, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0, "div -100/7"});
    vecs.push_back('{1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div 100/-7"});
    vecs.push_back('{1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, "div 5/0"});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div min/-1"});
    vecs.push_back('{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div -7/2"});
    vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, "div max/1"});

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    check_output("reset result", data_result, 32'd0);
    check_output("reset exception", {31'd0, data_exception}, 32'd0);
    check_output("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check_output("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].is_mul, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].name);

    // Restart: a DIV at edge 5 replaces the MULT started at edge 0.
    apply_stimulus(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (4) @(posedge clock);
    apply_stimulus(1'b0, 1'b1, 32'd20, 32'd3);
    pulses = 0;
    first_edge = -1;
    cap_res = '0;
    cap_exc = 1'b0;
    for (int n = 6; n <= 45; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = n;
          cap_res = data_result;
          cap_exc = data_exception;
        end
      end
    end
    check_output("restart rdy pulses", pulses, 32'd1);
    check_output("restart rdy edge", first_edge, 32'd38);
    check_output("restart result", cap_res, 32'd6);
    check_output("restart exception", {31'd0, cap_exc}, 32'd0);

    // Simultaneous MULT and DIV: the multiply is taken.
    apply_stimulus(1'b1, 1'b1, 32'd6, 32'd2);
    wait_rdy(edges);
    check_output("both starts latency", edges, MUL_LAT);
    check_output("both starts result", data_result, 32'd12);

    // Start issued in the same cycle as RDY.
    apply_stimulus(1'b1, 1'b0, 32'd5, 32'd5);
    wait_rdy(edges);
    check_output("chain first result", data_result, 32'd25);
    apply_stimulus(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    check_output("chain rdy dropped", {31'd0, data_resultRDY}, 32'd0);
    wait_rdy(edges);
    check_output("chain second latency", edges, DIV_LAT);
    check_output("chain second result", data_result, 32'hFFFF_FFF2);

    // Asynchronous reset in the middle of a divide.
    apply_stimulus(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (10) @(posedge clock);
    #1;
    check_output("busy before abort", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort result", data_result, 32'd0);
    check_output("abort exception", {31'd0, data_exception}, 32'd0);
    check_output("abort rdy", {31'd0, data_resultRDY}, 32'd0);
    check_output("abort busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int n = 11; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    check_output("no rdy after abort", pulses, 32'd0);
    run_op(1'b1, 32'd2, 32'd2, 32'd4, 1'b0, "post-reset mul");

    for (int i = 0; i < 24; i++) begin
      is_mul = $urandom_range(0, 1) == 1;
      a = rand_operand();
      b = rand_operand();
      model(is_mul, a, b, exp_res, exp_exc);
      run_op(is_mul, a, b, exp_res, exp_exc, is_mul ? "rand mul" : "rand div");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
